// File: rtl/phase_sweep_ctrl_if.sv
// Signal bundle between a phase-sweep controller and its host/shifter side.
// Handshake: start/abort/period_tick are single-cycle pulses sampled on rising clk; outputs are registered pulses/levels.
interface phase_sweep_ctrl_if;
    logic               start;
    logic               abort;
    logic signed [10:0] start_delay;
    logic signed [10:0] stop_delay;
    logic        [9:0]  step_size;
    logic        [7:0]  dwell;
    logic               period_tick;
    logic signed [10:0] delay_out;
    logic               delay_upd;
    logic               busy;
    logic               done;
    logic               err;
    logic        [1:0]  state_dbg;

    modport master (
        output start, abort, start_delay, stop_delay, step_size, dwell, period_tick,
        input  delay_out, delay_upd, busy, done, err, state_dbg
    );

    modport slave (
        input  start, abort, start_delay, stop_delay, step_size, dwell, period_tick,
        output delay_out, delay_upd, busy, done, err, state_dbg
    );
endinterface

// File: rtl/phase_sweep_ctrl.sv
// Steps a phase-shifter delay from start to stop, holding each value for a
// programmable number of shifter periods; delay_out is never driven to zero.
module phase_sweep_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    phase_sweep_ctrl_if.slave sweep
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic        [1:0]  state_q, state_d;
    logic signed [10:0] delay_q, delay_d;
    logic               upd_q, upd_d;
    logic               err_q, err_d;
    logic        [7:0]  cnt_q, cnt_d;
    logic signed [10:0] start_cfg_q, start_cfg_d;
    logic signed [10:0] stop_cfg_q, stop_cfg_d;
    logic        [9:0]  step_cfg_q, step_cfg_d;
    logic        [7:0]  dwell_cfg_q, dwell_cfg_d;
    logic               up_q, up_d;

    logic signed [11:0] delay_ext, step_ext, stop_ext, sum_raw, next_val;
    logic               out_of_range, past_stop, cfg_bad;

    // 12-bit arithmetic so an overshoot past the 11-bit range is seen, not wrapped
    assign delay_ext    = {delay_q[10], delay_q};
    assign step_ext     = {2'b00, step_cfg_q};
    assign stop_ext     = {stop_cfg_q[10], stop_cfg_q};
    assign sum_raw      = up_q ? (delay_ext + step_ext) : (delay_ext - step_ext);
    assign next_val     = (sum_raw == 12'sd0) ? (up_q ? 12'sd1 : -12'sd1) : sum_raw;
    assign out_of_range = (next_val > 12'sd1023) || (next_val < -12'sd1024);
    assign past_stop    = out_of_range || (up_q ? (next_val > stop_ext) : (next_val < stop_ext));

    assign cfg_bad = (sweep.start_delay == 11'sd0) || (sweep.stop_delay == 11'sd0) ||
                     (sweep.step_size == 10'd0) || (sweep.dwell == 8'd0);

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        upd_d       = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        start_cfg_d = start_cfg_q;
        stop_cfg_d  = stop_cfg_q;
        step_cfg_d  = step_cfg_q;
        dwell_cfg_d = dwell_cfg_q;
        up_d        = up_q;
        if (sweep.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sweep.start) begin
                        start_cfg_d = sweep.start_delay;
                        stop_cfg_d  = sweep.stop_delay;
                        step_cfg_d  = sweep.step_size;
                        dwell_cfg_d = sweep.dwell;
                        if (cfg_bad) begin
                            err_d = 1'b1;
                        end else begin
                            up_d    = (sweep.stop_delay >= sweep.start_delay);
                            state_d = S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (sweep.period_tick) begin
                        delay_d = start_cfg_q;
                        upd_d   = 1'b1;
                        cnt_d   = dwell_cfg_q;
                        state_d = S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (sweep.period_tick) begin
                        if (cnt_q == 8'd1) begin
                            if (past_stop) begin
                                state_d = S_DONE;
                            end else begin
                                delay_d = next_val[10:0];
                                upd_d   = 1'b1;
                                cnt_d   = dwell_cfg_q;
                            end
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            delay_q     <= 11'sd1;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
            start_cfg_q <= 11'sd0;
            stop_cfg_q  <= 11'sd0;
            step_cfg_q  <= 10'd0;
            dwell_cfg_q <= 8'd0;
            up_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            start_cfg_q <= start_cfg_d;
            stop_cfg_q  <= stop_cfg_d;
            step_cfg_q  <= step_cfg_d;
            dwell_cfg_q <= dwell_cfg_d;
            up_q        <= up_d;
        end
    end

    assign sweep.delay_out = delay_q;
    assign sweep.delay_upd = upd_q;
    assign sweep.busy      = (state_q == S_ARM) || (state_q == S_DWELL);
    assign sweep.done      = (state_q == S_DONE);
    assign sweep.err       = err_q;
    assign sweep.state_dbg = state_q;

endmodule

// File: doc/phase_sweep_ctrl.md
PHASE_SWEEP_CTRL -- requirements
Module: phase_sweep_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle sweep request.
REQ-004 abort  input  1  one-cycle sweep cancel.
REQ-005 start_delay  input  11 signed  first delay of sweep.
REQ-006 stop_delay  input  11 signed  sweep end bound, inclusive.
REQ-007 step_size  input  10 unsigned  delay increment magnitude per step.
REQ-008 dwell  input  8 unsigned  shifter periods held per step.
REQ-009 period_tick  input  1  one-cycle pulse at each shifter counter wrap (once per 625 clk).
REQ-010 delay_out  output  11 signed  delay value driven to the shifter.
REQ-011 delay_upd  output  1  one-cycle pulse after each delay_out change.
REQ-012 busy  output  1  high while a sweep is active.
REQ-013 done  output  1  one-cycle pulse on normal sweep completion.
REQ-014 err  output  1  one-cycle pulse on rejected configuration.

Function
REQ-015 States SHALL be IDLE, ARM, DWELL, DONE; busy SHALL be 1 exactly in ARM and DWELL.
REQ-016 In IDLE, start SHALL capture start_delay, stop_delay, step_size, dwell into internal registers; later input changes SHALL not affect the running sweep.
REQ-017 start with start_delay==0, stop_delay==0, step_size==0 or dwell==0 SHALL pulse err the next cycle and remain IDLE.
REQ-018 Valid start SHALL enter ARM; direction SHALL be up if stop_delay >= start_delay, else down.
REQ-019 start while busy SHALL be ignored.
REQ-020 ARM: on period_tick, delay_out SHALL load start_delay on that edge, delay_upd SHALL pulse the following cycle, dwell counter SHALL load dwell, state -> DWELL.
REQ-021 DWELL: each period_tick SHALL decrement the dwell counter; delay_out SHALL change only on a period_tick edge.
REQ-022 On period_tick with dwell counter ==1: next = delay_out +/- step_size computed in 12-bit signed arithmetic (no wrap).
REQ-023 If next==0, next SHALL be replaced by +1 (up) or -1 (down); delay_out SHALL never be 0.
REQ-024 If next > stop (up) or next < stop (down), state SHALL -> DONE with delay_out unchanged; otherwise delay_out <= next, delay_upd pulses, dwell counter reloads.
REQ-025 Values outside [-1024,1023] SHALL be treated as past stop_delay.
REQ-026 start_delay == stop_delay SHALL produce one step held dwell periods, then DONE.
REQ-027 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-028 abort SHALL force IDLE on the next edge from any state, no done pulse, delay_out held; abort SHALL take priority over period_tick and start in the same cycle.
REQ-029 In IDLE and DONE, delay_out SHALL hold its last value.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, delay_out=1, delay_upd=0, busy=0, done=0, err=0, dwell counter=0, captured config=0.
REQ-031 rst_n release mid-sweep SHALL resume in IDLE; no sweep SHALL restart without a new start.

Verification
REQ-032 start_delay=-3, stop=3, step=2, dwell=1 -> delay_out sequence -3,-1,1,3 each on consecutive period_ticks, then done pulse; 0 never driven.
REQ-033 start_delay=10, stop=4, step=3, dwell=2 -> 10,7,4 each held 2 periods; done after 6th tick since ARM exit.
REQ-034 start_delay=1000, stop=1023, step=500 -> 1000 for dwell periods, next (1500) past bound -> DONE, delay_out stays 1000.
REQ-035 step_size=0 or start_delay=0 -> err pulse one cycle, busy stays 0, delay_out unchanged.
REQ-036 abort asserted same cycle as period_tick in DWELL -> IDLE next cycle, delay_out unchanged, no delay_upd, no done.
REQ-037 rst_n low mid-DWELL -> outputs at reset values asynchronously; start ignored until rst_n high.
